// File: rtl/rv32_uart_xcvr_if.sv
// rv32_uart_xcvr_if: core-side TX/RX handshake bundle for the console UART.
// master = core/bench side, slave = transceiver side.
interface rv32_uart_xcvr_if;
  logic [31:0] data_tx;
  logic [1:0]  tx_bytes;
  logic        new_data;
  logic        ready;
  logic [31:0] data_rx;
  logic        rx_valid;
  logic        rx_err;

  modport master (
    output data_tx,
    output tx_bytes,
    output new_data,
    input  ready,
    input  data_rx,
    input  rx_valid,
    input  rx_err
  );

  modport slave (
    input  data_tx,
    input  tx_bytes,
    input  new_data,
    output ready,
    output data_rx,
    output rx_valid,
    output rx_err
  );
endinterface

// File: rtl/rv32_uart_xcvr.sv
// rv32_uart_xcvr: full-duplex console UART, 1-4 byte LSB-first TX bursts,
// 2-FF synchronised RX shifting each good byte into a 32-bit word.
module rv32_uart_xcvr #(
  parameter int CLKS_PER_BIT = 10417,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst,
  rv32_uart_xcvr_if.slave bus,
  output logic            RsTx,
  input  logic            RsRx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST =
    CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    T_IDLE, T_START, T_DATA, T_PAR, T_STOP
  } tx_st_e;

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_PAR, R_STOP
  } rx_st_e;

  tx_st_e      tx_st, tx_nxt;
  logic [CW-1:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic        tx_sb;
  logic [1:0]  tx_left;
  logic [31:0] tx_word;
  logic [7:0]  tx_byte;
  logic        tx_tick;
  logic        tx_sb_last;
  logic        tx_par;

  assign tx_byte    = tx_word[7:0];
  assign tx_tick    = (tx_cnt == LAST);
  assign tx_sb_last = (STOP_BITS == 1) || tx_sb;
  assign tx_par     = (^tx_byte) ^ PARITY_ODD;
  assign bus.ready  = (tx_st == T_IDLE);

  always_comb begin
    tx_nxt = tx_st;
    unique case (tx_st)
      T_IDLE:
        if (bus.new_data) tx_nxt = T_START;
      T_START:
        if (tx_tick) tx_nxt = T_DATA;
      T_DATA:
        if (tx_tick && tx_bit == 3'd7)
          tx_nxt = PARITY_EN ? T_PAR : T_STOP;
      T_PAR:
        if (tx_tick) tx_nxt = T_STOP;
      T_STOP:
        if (tx_tick && tx_sb_last)
          tx_nxt = (tx_left != 2'd0) ? T_START
                                     : T_IDLE;
      default:
        tx_nxt = T_IDLE;
    endcase
  end

  always_comb begin
    RsTx = 1'b1;
    unique case (tx_st)
      T_START: RsTx = 1'b0;
      T_DATA:  RsTx = tx_byte[tx_bit];
      T_PAR:   RsTx = tx_par;
      default: RsTx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st   <= T_IDLE;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sb   <= 1'b0;
      tx_left <= '0;
      tx_word <= '0;
    end else begin
      tx_st  <= tx_nxt;
      tx_cnt <= (tx_st == T_IDLE || tx_tick) ? '0
                                             : tx_cnt + 1'b1;
      if (tx_st == T_IDLE && bus.new_data) begin
        tx_word <= bus.data_tx;
        tx_left <= bus.tx_bytes;
      end
      if (tx_st == T_DATA && tx_tick)
        tx_bit <= tx_bit + 3'd1;
      if (tx_st == T_STOP && tx_tick) begin
        tx_sb <= ~tx_sb_last;
        // next byte of the burst moves into the low lane
        if (tx_sb_last && tx_left != 2'd0) begin
          tx_word <= {8'h00, tx_word[31:8]};
          tx_left <= tx_left - 2'd1;
        end
      end
    end
  end

  rx_st_e      rx_st, rx_nxt;
  logic        rx_s1, rx_s2;
  logic [CW-1:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic        rx_pbit;
  logic        rx_tick;
  logic        rx_par_ok;
  logic [31:0] rx_word;
  logic        rx_vld_q;
  logic        rx_err_q;

  assign rx_tick = (rx_st == R_START) ? (rx_cnt == HALF_LAST)
                                      : (rx_cnt == LAST);
  assign rx_par_ok = !PARITY_EN ||
    (rx_pbit == ((^rx_sh) ^ PARITY_ODD));

  assign bus.data_rx  = rx_word;
  assign bus.rx_valid = rx_vld_q;
  assign bus.rx_err   = rx_err_q;

  always_comb begin
    rx_nxt = rx_st;
    unique case (rx_st)
      R_IDLE:
        if (!rx_s2) rx_nxt = R_START;
      R_START:
        if (rx_tick)
          rx_nxt = rx_s2 ? R_IDLE : R_DATA;
      R_DATA:
        if (rx_tick && rx_bit == 3'd7)
          rx_nxt = PARITY_EN ? R_PAR : R_STOP;
      R_PAR:
        if (rx_tick) rx_nxt = R_STOP;
      R_STOP:
        if (rx_tick) rx_nxt = R_IDLE;
      default:
        rx_nxt = R_IDLE;
    endcase
  end

  // synchroniser resets high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= RsRx;
      rx_s2 <= rx_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st    <= R_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_pbit  <= 1'b0;
      rx_word  <= '0;
      rx_vld_q <= 1'b0;
      rx_err_q <= 1'b0;
    end else begin
      rx_st    <= rx_nxt;
      rx_vld_q <= 1'b0;
      rx_err_q <= 1'b0;
      rx_cnt <= (rx_st == R_IDLE || rx_tick) ? '0
                                             : rx_cnt + 1'b1;
      if (rx_st == R_DATA && rx_tick) begin
        rx_sh  <= {rx_s2, rx_sh[7:1]};
        rx_bit <= rx_bit + 3'd1;
      end
      if (rx_st == R_PAR && rx_tick)
        rx_pbit <= rx_s2;
      if (rx_st == R_STOP && rx_tick) begin
        if (rx_s2 && rx_par_ok) begin
          rx_word  <= {rx_word[23:0], rx_sh};
          rx_vld_q <= 1'b1;
        end else begin
          rx_err_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rv32_uart_xcvr.sv
// tb_rv32_uart_xcvr: directed scoreboard bench for the console UART.
// u0: 8N1 with optional TX->RX loopback; u1: 8E1 driven by the bench.
module tb_rv32_uart_xcvr;
  localparam int CPB = 4;

  logic clk;
  logic rst;
  logic tx0, tx1, rx0, rx1, rx0_tb, loop;
  int   n_cmp;
  int   n_bad;

  logic [1:0]  exp_tx[$];
  logic [33:0] exp_rx[$];

  rv32_uart_xcvr_if bus0();
  rv32_uart_xcvr_if bus1();

  assign rx0 = loop ? tx0 : rx0_tb;

  rv32_uart_xcvr #(
    .CLKS_PER_BIT(CPB)
  ) u0 (
    .clk(clk), .rst(rst), .bus(bus0.slave),
    .RsTx(tx0), .RsRx(rx0)
  );

  rv32_uart_xcvr #(
    .CLKS_PER_BIT(CPB),
    .PARITY_EN(1'b1),
    .PARITY_ODD(1'b0),
    .STOP_BITS(1)
  ) u1 (
    .clk(clk), .rst(rst), .bus(bus1.slave),
    .RsTx(tx1), .RsRx(rx1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [33:0] obs,
                       input logic [33:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++)
      repeat (CPB) exp_tx.push_back({f[i], 1'b0});
  endtask

  // pops one {RsTx, ready} expectation per cycle after acceptance
  task automatic drain_tx(input logic [31:0] next_word,
                          input int drop_at);
    logic [1:0] e;
    int k;
    k = 0;
    while (exp_tx.size() != 0) begin
      tick();
      k++;
      if (k == 1) begin
        bus0.data_tx  = next_word;
        bus0.tx_bytes = 2'd0;
      end
      if (k == drop_at) bus0.new_data = 1'b0;
      e = exp_tx.pop_front();
      check("tx_line_ready", {32'd0, tx0, bus0.ready},
            {32'd0, e});
    end
  endtask

  task automatic watch(input logic v, input logic e,
                       input logic [31:0] d,
                       input string tag);
    if (v || e) begin
      if (exp_rx.size() == 0)
        check({tag, "_extra"}, {v, e, d}, 34'd0);
      else
        check(tag, {v, e, d}, exp_rx.pop_front());
    end
  endtask

  task automatic rx1_bit(input logic v);
    rx1 = v;
    repeat (CPB) begin
      tick();
      watch(bus1.rx_valid, bus1.rx_err,
            bus1.data_rx, "rx1_event");
    end
  endtask

  task automatic rx1_frame(input logic [7:0] b,
                           input logic par,
                           input logic stop);
    rx1_bit(1'b0);
    for (int i = 0; i < 8; i++) rx1_bit(b[i]);
    rx1_bit(par);
    rx1_bit(stop);
    rx1_bit(1'b1);
    rx1_bit(1'b1);
  endtask

  initial begin
    int k;
    int pulses;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    loop = 1'b0;
    rx0_tb = 1'b1;
    rx1 = 1'b1;
    bus0.data_tx = '0;
    bus0.tx_bytes = '0;
    bus0.new_data = 1'b0;
    bus1.data_tx = '0;
    bus1.tx_bytes = '0;
    bus1.new_data = 1'b0;
    repeat (3) tick();
    check("rst_tx_ready", {32'd0, tx0, bus0.ready}, 34'd3);
    check("rst_rx0", {bus0.rx_valid, bus0.rx_err,
          bus0.data_rx}, 34'd0);
    check("rst_rx1", {bus1.rx_valid, bus1.rx_err,
          bus1.data_rx}, 34'd0);
    rst = 1'b0;

    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle_quiet", {30'd0, tx0, bus0.ready,
            bus0.rx_valid, bus0.rx_err}, 34'b1100);
    end

    // single byte A5
    bus0.data_tx = 32'h0000_00A5;
    bus0.tx_bytes = 2'd0;
    bus0.new_data = 1'b1;
    push_frame(8'hA5);
    exp_tx.push_back(2'b11);
    drain_tx(32'h0, 1);

    // four bytes, new_data held: second word on ready rise
    bus0.data_tx = 32'h1234_5678;
    bus0.tx_bytes = 2'd3;
    bus0.new_data = 1'b1;
    push_frame(8'h78);
    push_frame(8'h56);
    push_frame(8'h34);
    push_frame(8'h12);
    exp_tx.push_back(2'b11);
    push_frame(8'hC3);
    exp_tx.push_back(2'b11);
    drain_tx(32'h0000_00C3, 162);

    // loopback DEAD_BEEF
    loop = 1'b1;
    exp_rx.push_back({2'b10, 32'h0000_00EF});
    exp_rx.push_back({2'b10, 32'h0000_EFBE});
    exp_rx.push_back({2'b10, 32'h00EF_BEAD});
    exp_rx.push_back({2'b10, 32'hEFBE_ADDE});
    bus0.data_tx = 32'hDEAD_BEEF;
    bus0.tx_bytes = 2'd3;
    bus0.new_data = 1'b1;
    tick();
    bus0.new_data = 1'b0;
    k = 0;
    pulses = 0;
    while ((exp_rx.size() != 0 || !bus0.ready) && k < 400) begin
      tick();
      k++;
      if (bus0.rx_err) pulses++;
      watch(bus0.rx_valid, bus0.rx_err,
            bus0.data_rx, "lb_event");
    end
    check("lb_pending", 34'(exp_rx.size()), 34'd0);
    check("lb_timeout", 34'(k >= 400), 34'd0);
    check("lb_err_count", 34'(pulses), 34'd0);
    check("lb_final", {2'b00, bus0.data_rx},
          {2'b00, 32'hEFBE_ADDE});
    loop = 1'b0;
    exp_rx.delete();

    // parity/stop errors on u1 (even parity)
    exp_rx.push_back({2'b10, 32'h0000_0003});
    rx1_frame(8'h03, 1'b0, 1'b1);
    exp_rx.push_back({2'b01, 32'h0000_0003});
    rx1_frame(8'h03, 1'b1, 1'b1);
    exp_rx.push_back({2'b01, 32'h0000_0003});
    rx1_frame(8'h5A, 1'b0, 1'b0);
    exp_rx.push_back({2'b10, 32'h0000_0381});
    rx1_frame(8'h81, 1'b0, 1'b1);
    check("par_pending", 34'(exp_rx.size()), 34'd0);

    // one-cycle glitch
    pulses = 0;
    rx1 = 1'b0;
    tick();
    rx1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus1.rx_valid || bus1.rx_err) pulses++;
      tick();
    end
    check("glitch_pulses", 34'(pulses), 34'd0);
    check("glitch_data", {2'b00, bus1.data_rx},
          {2'b00, 32'h0000_0381});

    // reset mid-frame
    bus0.data_tx = 32'hFFFF_FFFF;
    bus0.tx_bytes = 2'd3;
    bus0.new_data = 1'b1;
    tick();
    bus0.new_data = 1'b0;
    check("busy_before_rst", {32'd0, bus0.ready}, 34'd0);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    check("midrst_tx_ready", {32'd0, tx0, bus0.ready}, 34'd3);
    check("midrst_rx0", {bus0.rx_valid, bus0.rx_err,
          bus0.data_rx}, 34'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_rst_idle", {32'd0, tx0, bus0.ready}, 34'd3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
